mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between instruction fetch (IF) and

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data side has fixed priority; every granted access ends in a one-cycle valid pulse.
//
// state | meaning
// IDLE  | no access in flight, arbitrate (data before fetch)
// FETCH | fetch access outstanding on the memory port
// DATA  | load/store access outstanding on the memory port
// DONE  | owner's valid pulse, no arbitration
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                    clock_i,
    input  logic                    reset_i,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_flush_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_valid_o,
    output logic                    if_stall_o,

    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dm_byte_en_i,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    dm_valid_o,
    output logic                    dm_stall_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic                    bus_error_o
);

    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int WAIT_WIDTH = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(MAX_WAIT);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [BE_WIDTH-1:0]     mem_be_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic [DATA_WIDTH-1:0]   dm_rdata_q;
    logic                    if_valid_q;
    logic                    dm_valid_q;
    logic                    bus_error_q;
    logic                    discard_q;
    logic [WAIT_WIDTH-1:0]   wait_q;
    logic [WAIT_WIDTH-1:0]   wait_d;
    logic                    fetch_drop;

    // Wait budget counts down from MAX_WAIT; hitting the last unit without ready is the timeout.
    assign wait_d     = wait_q - WAIT_LAST;
    assign fetch_drop = discard_q | if_flush_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            bus_error_q <= 1'b0;
            discard_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    discard_q <= 1'b0;
                    if (dm_req_i) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        mem_be_q    <= dm_byte_en_i;
                        wait_q      <= WAIT_LOAD;
                        state_q     <= ST_DATA;
                    end else if (if_req_i && !if_flush_i) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                        wait_q      <= WAIT_LOAD;
                        state_q     <= ST_FETCH;
                    end
                end
                ST_FETCH, ST_DATA: begin
                    if (state_q == ST_FETCH && if_flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        if (state_q == ST_DATA) begin
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata_i;
                            end
                            dm_valid_q <= 1'b1;
                        end else if (!fetch_drop) begin
                            if_rdata_q <= mem_rdata_i;
                            if_valid_q <= 1'b1;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        mem_req_q   <= 1'b0;
                        bus_error_q <= 1'b1;
                        state_q     <= ST_DONE;
                        if (state_q == ST_DATA) begin
                            dm_rdata_q <= '0;
                            dm_valid_q <= 1'b1;
                        end else if (!fetch_drop) begin
                            if_rdata_q <= '0;
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_DONE: begin
                    discard_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stalls mirror the request lines while reset is held.
    assign if_stall_o = if_req_i & ~(if_valid_q & ~reset_i);
    assign dm_stall_o = dm_req_i & ~(dm_valid_q & ~reset_i);

    assign if_rdata_o    = if_rdata_q;
    assign if_valid_o    = if_valid_q;
    assign dm_rdata_o    = dm_rdata_q;
    assign dm_valid_o    = dm_valid_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_byte_en_o = mem_be_q;
    assign bus_error_o   = bus_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by concurrent
// random fetch/data traffic against a memory responder with random latency.
module tb_mem_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          if_req, if_flush;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          if_valid, if_stall;
    logic          dm_req, dm_we;
    logic [31:0]   dm_addr, dm_wdata;
    logic [3:0]    dm_be;
    logic [31:0]   dm_rdata;
    logic          dm_valid, dm_stall;
    logic          mem_req, mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic          bus_error;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_rdata_o(if_rdata), .if_valid_o(if_valid), .if_stall_o(if_stall),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_byte_en_i(dm_be), .dm_rdata_o(dm_rdata), .dm_valid_o(dm_valid), .dm_stall_o(dm_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_byte_en_o(mem_be), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .bus_error_o(bus_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference memory (model side) and responder storage (memory side), same initial image.
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    logic [31:0] if_exp_q[$];
    logic [31:0] dm_exp_q[$];
    int          grant_log[$];
    logic [31:0] last_if = 32'h0;
    logic [31:0] last_dm = 32'h0;

    int force_lat       = -1;
    bit hang            = 1'b0;
    bit expect_suppress = 1'b0;

    // Memory responder: random latency, field stability, grant identification, valid latency.
    initial begin
        int          wait_cnt;
        int          lat;
        int          who;
        logic [31:0] c_addr, c_wdata;
        logic        c_we;
        logic [3:0]  c_be;
        wait_cnt = 0; lat = 0; c_addr = 0; c_wdata = 0; c_we = 0; c_be = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                check("mem_req_drop", 32'(mem_req), 0);
                check("valid_latency", 32'(if_valid | dm_valid), expect_suppress ? 0 : 1);
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) begin
                    c_addr = mem_addr; c_we = mem_we; c_wdata = mem_wdata; c_be = mem_be;
                    lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                    if (dm_req && c_we == dm_we && c_addr == dm_addr &&
                        (!dm_we || (c_wdata == dm_wdata && c_be == dm_be)))
                        who = 1;
                    else if (if_req && !c_we && c_addr == if_addr)
                        who = 0;
                    else
                        who = 2;
                    grant_log.push_back(who);
                    check("mem_grant_match", 32'(who != 2), 1);
                end else begin
                    check("mem_stable", 32'(mem_addr == c_addr && mem_we == c_we &&
                                            mem_wdata == c_wdata && mem_be == c_be), 1);
                end
                if (!hang && wait_cnt == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = phys_rd(c_addr);
                    if (c_we) phys_mem[c_addr] = merge(phys_rd(c_addr), c_wdata, c_be);
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: stall equations every cycle, pop scoreboard on each valid pulse.
    initial begin
        forever begin
            @(negedge clk);
            check("if_stall", 32'(if_stall), 32'(reset ? if_req : (if_req & ~if_valid)));
            check("dm_stall", 32'(dm_stall), 32'(reset ? dm_req : (dm_req & ~dm_valid)));
            if (if_valid) begin
                if (if_exp_q.size() == 0) check("if_valid_unexpected", 32'(if_valid), 0);
                else check("if_rdata", if_rdata, if_exp_q.pop_front());
            end
            if (dm_valid) begin
                if (dm_exp_q.size() == 0) check("dm_valid_unexpected", 32'(dm_valid), 0);
                else check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_fetch(input logic [31:0] a, output int cyc);
        logic [31:0] e;
        bit          got;
        e = ref_rd(a);
        if_addr = a;
        if_req  = 1'b1;
        if_exp_q.push_back(e);
        last_if = e;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (if_valid) got = 1'b1;
        end
        if (!got) check("if_valid_timeout", 32'(if_valid), 1);
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int cyc);
        logic [31:0] e;
        bit          got;
        if (we) begin
            ref_mem[a] = merge(ref_rd(a), wd, be);
            e = last_dm;
        end else begin
            e = ref_rd(a);
            last_dm = e;
        end
        dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
        dm_req = 1'b1;
        dm_exp_q.push_back(e);
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (dm_valid) got = 1'b1;
        end
        if (!got) check("dm_valid_timeout", 32'(dm_valid), 1);
        dm_req = 1'b0;
    endtask

    int c1, c2, gl0, cnt;
    bit seen;

    initial begin
        reset = 1'b1;
        if_req = 0; if_flush = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_valids", 32'({if_valid, dm_valid}), 0);
        check("rst_bus_error", 32'(bus_error), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Plain fetch, ready two cycles after mem_req rises.
        ref_mem[32'h10]  = 32'h00500093;
        phys_mem[32'h10] = 32'h00500093;
        force_lat = 2;
        do_fetch(32'h10, c1);
        check("t1_if_rdata", if_rdata, 32'h00500093);
        check("t1_latency", 32'(c1), 4);
        force_lat = -1;
        @(posedge clk); #1;

        // Simultaneous requests: data first, then fetch.
        gl0 = grant_log.size();
        fork
            do_fetch(32'h14, c1);
            do_dm(1'b0, 32'h100, 32'h0, 4'h0, c2);
        join
        check("t2_first_grant_dm", 32'(grant_log[gl0]), 1);
        check("t2_second_grant_if", 32'(grant_log[gl0 + 1]), 0);
        check("t2_dm_before_if", 32'(c2 < c1), 1);
        @(posedge clk); #1;

        // Store leaves dm_rdata alone.
        do_dm(1'b1, 32'h200, 32'hDEADBEEF, 4'hF, c2);
        check("t3_dm_rdata_kept", dm_rdata, ref_rd(32'h100));
        check("t3_store_written", phys_rd(32'h200), 32'hDEADBEEF);
        @(posedge clk); #1;

        // Flush in the middle of a fetch, then refetch from the new address.
        force_lat = 3;
        if_addr = 32'h30;
        if_req  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (mem_req) seen = 1'b1;
        end
        check("t4_fetch_started", 32'(mem_req), 1);
        @(posedge clk); #1;
        if_flush = 1'b1;
        if_addr  = 32'h40;
        expect_suppress = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (!mem_req) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("t4_flushed_access_done", 32'(mem_req), 0);
        check("t4_if_rdata_held", if_rdata, last_if);
        @(posedge clk);
        @(negedge clk);
        expect_suppress = 1'b0;
        if_exp_q.push_back(ref_rd(32'h40));
        last_if = ref_rd(32'h40);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (if_valid) seen = 1'b1;
        end
        check("t4_refetch_valid", 32'(if_valid), 1);
        if_req = 1'b0;
        force_lat = -1;
        @(posedge clk); #1;

        // Timeout with memory never ready.
        hang = 1'b1;
        dm_we = 1'b0; dm_addr = 32'h300; dm_req = 1'b1;
        dm_exp_q.push_back(32'h0);
        last_dm = 32'h0;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (dm_valid) seen = 1'b1;
            else if (mem_req) cnt++;
        end
        check("t5_timeout_valid", 32'(dm_valid), 1);
        check("t5_req_cycles", 32'(cnt), 32'(MAX_WAIT));
        check("t5_bus_error", 32'(bus_error), 1);
        check("t5_rdata_zero", dm_rdata, 0);
        dm_req = 1'b0;
        hang = 1'b0;
        @(posedge clk); #1;
        do_dm(1'b0, 32'h300, 32'h0, 4'h0, c2);
        check("t5_bus_error_sticky", 32'(bus_error), 1);
        @(posedge clk); #1;

        // Reset in the middle of a data access.
        hang = 1'b1;
        dm_we = 1'b0; dm_addr = 32'h400; dm_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (mem_req) seen = 1'b1;
        end
        check("t6_access_started", 32'(mem_req), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_mem_req", 32'(mem_req), 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_dm_valid", 32'(dm_valid), 0);
        check("t6_bus_error", 32'(bus_error), 0);
        check("t6_dm_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        hang = 1'b0;
        last_dm = 32'h0;
        last_if = 32'h0;
        repeat (6) @(posedge clk);
        #1;

        // Concurrent random traffic from both requesters, disjoint address regions.
        fork
            begin
                int gap, cy;
                for (int i = 0; i < 40; i++) begin
                    gap = int'($urandom_range(0, 3));
                    repeat (gap) begin @(posedge clk); #1; end
                    do_fetch(32'h800 + (32'($urandom_range(0, 63)) << 2), cy);
                end
            end
            begin
                int gap, cy;
                for (int i = 0; i < 40; i++) begin
                    gap = int'($urandom_range(0, 3));
                    repeat (gap) begin @(posedge clk); #1; end
                    do_dm(1'($urandom_range(0, 1)), 32'h1000 + (32'($urandom_range(0, 15)) << 2),
                          $urandom(), 4'($urandom_range(0, 15)), cy);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("final_if_queue_empty", 32'(if_exp_q.size()), 0);
        check("final_dm_queue_empty", 32'(dm_exp_q.size()), 0);
        check("final_bus_error", 32'(bus_error), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
